// File: rtl/ror_seq.sv
// Sequential rotate-right unit: rotates one bit per clock,
// reports completion with a one-cycle done pulse.
module ror_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [WIDTH-1:0]   Rb,
  input  logic [SHAMT_W-1:0] Rc,
  output logic [WIDTH-1:0]   Ra,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic [WIDTH-1:0]   rot1;

  assign rot1 = {work_q[0], work_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      ra_q    <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      ra_q    <= ra_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    ra_d    = ra_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          work_d = Rb;
          cnt_d  = Rc;
          // A zero amount skips SHIFT and publishes the operand as-is
          if (Rc == '0) begin
            state_d = DONE;
            ra_d    = Rb;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = rot1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
          ra_d    = rot1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Ra   = ra_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_ror_seq.sv
// Self-checking bench for ror_seq: scoreboard of expected
// results and completion cycles, checked when done pulses.
module tb_ror_seq;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] Rb;
  logic [4:0]  Rc;
  logic [31:0] Ra;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_ra;

  ror_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk  (clk),
    .clr  (clr),
    .start(start),
    .Rb   (Rb),
    .Rc   (Rc),
    .Ra   (Ra),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ror_ref(logic [31:0] x, int r);
    logic [63:0] d;
    d = {x, x} >> r;
    return d[31:0];
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!clr && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: cyc=%0d Ra=%h", cyc, Ra);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (Ra !== e.data) begin
          errors++;
          $display("FAIL result: got %h expected %h", Ra, e.data);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL latency: done at cyc %0d expected %0d", cyc, e.due);
        end
        last_ra = e.data;
      end
    end
  end

  task automatic push_exp(logic [31:0] rb, int rc, int base);
    exp_t e;
    e.data = ror_ref(rb, rc);
    e.due  = base + rc;
    sb.push_back(e);
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d results pending expected 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Drive one start pulse; returns the cycle index after the accept edge.
  task automatic launch(logic [31:0] rb, logic [4:0] rc, output int base);
    @(negedge clk);
    Rb    = rb;
    Rc    = rc;
    start = 1'b1;
    base  = cyc + 1;
    push_exp(rb, int'(rc), base);
    @(negedge clk);
    start = 1'b0;
    Rb    = $urandom;
    Rc    = 5'($urandom);
  endtask

  task automatic test_reset;
    clr   = 1'b1;
    start = 1'b0;
    Rb    = '0;
    Rc    = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (Ra !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: Ra=%h busy=%b done=%b expected 0/0/0", Ra, busy, done);
    end
    clr     = 1'b0;
    last_ra = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_rot1;
    int base;
    launch(32'h8000_0001, 5'd1, base);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL rot1_busy: busy=%b done=%b expected 1/0", busy, done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || Ra !== 32'hC000_0000) begin
      errors++;
      $display("FAIL rot1_done: busy=%b Ra=%h expected 0/c0000000", busy, Ra);
    end
    wait_drain("rot1");
  endtask

  task automatic test_rc0;
    int base;
    @(negedge clk);
    Rb    = 32'hDEAD_BEEF;
    Rc    = 5'd0;
    start = 1'b1;
    base  = cyc + 1;
    push_exp(Rb, 0, base);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL rc0_flags: busy=%b done=%b expected 0/1", busy, done);
    end
    wait_drain("rc0");
  endtask

  task automatic test_rc31;
    int base;
    launch(32'h0000_0001, 5'd31, base);
    wait_drain("rc31");
    checks++;
    if (Ra !== 32'h0000_0002) begin
      errors++;
      $display("FAIL rc31_hold: Ra=%h expected 00000002", Ra);
    end
  endtask

  task automatic test_ignore;
    int base;
    logic [31:0] prev;
    prev = last_ra;
    launch(32'h1234_5678, 5'd8, base);
    @(negedge clk);
    Rb    = 32'hFFFF_FFFF;
    Rc    = 5'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (Ra !== prev || busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_mid: Ra=%h busy=%b expected %h/1", Ra, busy, prev);
    end
    wait_drain("ignore");
    checks++;
    if (Ra !== 32'h7812_3456) begin
      errors++;
      $display("FAIL ignore_result: Ra=%h expected 78123456", Ra);
    end
  endtask

  task automatic test_clr_abort;
    int base;
    launch(32'hA5A5_0F0F, 5'd16, base);
    repeat (3) @(negedge clk);
    #2 clr = 1'b1;
    start  = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (Ra !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL clr_async: Ra=%h busy=%b done=%b expected 0/0/0", Ra, busy, done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL clr_start_ignored: busy=%b done=%b expected 0/0", busy, done);
    end
    start = 1'b0;
    clr   = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (Ra !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_after: Ra=%h busy=%b expected 0/0", Ra, busy);
    end
    last_ra = 32'h0;
  endtask

  task automatic test_back_to_back;
    int base;
    @(negedge clk);
    Rb    = 32'hF000_0000;
    Rc    = 5'd4;
    start = 1'b1;
    base  = cyc + 1;
    for (int k = 0; k < 4; k++) push_exp(Rb, 4, base + 5 * k);
    while (cyc < base + 15) @(negedge clk);
    start = 1'b0;
    wait_drain("b2b");
    checks++;
    if (Ra !== 32'h0F00_0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final: Ra=%h busy=%b expected 0f000000/0", Ra, busy);
    end
  endtask

  task automatic test_random;
    int base;
    for (int i = 0; i < 6; i++) begin
      launch($urandom, 5'($urandom), base);
      wait_drain("random");
    end
  endtask

  initial begin
    test_reset();
    test_rot1();
    test_rc0();
    test_rc31();
    test_ignore();
    test_clr_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
